cpu_prefetch_unit: RTL and testbench

Parametrised instruction prefetch unit between the ARMv4T core's fetch stage and the memory port. It replaces the core's single blocking fetch (one read, wait for `mem_ok`, decode) with a DEPTH-entry word buffer that keeps issuing sequential reads ahead of execution. It serves 32-bit ARM or 16-bit Thumb instructions to the core through a valid/ready handshake. A branch, exception or BX redirects it with a one-cycle flush; in-flight reads that cannot be aborted are discarded.

---
 rtl/cpu_prefetch_unit_pkg.sv | 18 +
 rtl/cpu_prefetch_unit_if.sv | 29 ++
 rtl/cpu_prefetch_unit_pf_fifo.sv | 50 +++++
 rtl/cpu_prefetch_unit.sv | 104 ++++++++++
 tb/tb_cpu_prefetch_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_prefetch_unit_pkg.sv
// Shared CPU definitions: reset vector, memory width codes, prefetch FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam logic [31:0] RESET_PC = 32'h0800_0000;

  localparam logic [1:0] MW_BYTE = 2'd0;
  localparam logic [1:0] MW_HALF = 2'd1;
  localparam logic [1:0] MW_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } pf_state_e;

endpackage

// File: rtl/cpu_prefetch_unit_if.sv
// Prefetch unit bundle: core redirect/delivery signals plus the memory read port.
// Latency: none, wires only.
// Backpressure: instr_valid/instr_ready toward the core; mem_read is held until mem_ok.
interface cpu_prefetch_unit_if;
  logic        flush;
  logic [31:0] flush_pc;
  logic        flush_thumb;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] mem_addr;
  logic [1:0]  mem_width;
  logic        mem_read;
  logic [31:0] mem_rdata;
  logic        mem_ok;

  // The prefetch unit itself.
  modport master (
    input  flush, flush_pc, flush_thumb, instr_ready, mem_rdata, mem_ok,
    output instr_valid, instr, instr_pc, mem_addr, mem_width, mem_read
  );

  // Core plus memory slave on the other side.
  modport slave (
    output flush, flush_pc, flush_thumb, instr_ready, mem_rdata, mem_ok,
    input  instr_valid, instr, instr_pc, mem_addr, mem_width, mem_read
  );
endinterface

// File: rtl/cpu_prefetch_unit_pf_fifo.sv
// Synchronous word FIFO with clear; head is visible without a pop.
// Latency: a push is visible at the head one cycle later.
// Backpressure: none internally; the caller never pushes into a full FIFO without also popping.
module pf_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic                    i_clear,
  input  logic [WIDTH-1:0]        i_dat,
  output logic [WIDTH-1:0]        o_head,
  output logic [$clog2(DEPTH):0]  o_count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;

  // Pointers and occupancy; clear overrides push and pop, pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (!rstn || i_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (i_pop)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage write; a cleared cycle stores nothing.
  always_ff @(posedge clk) begin
    if (i_push && !i_clear) r_mem[r_wr_ptr] <= i_dat;
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;
endmodule

// File: rtl/cpu_prefetch_unit.sv
// Instruction prefetch: keeps DEPTH words read ahead and serves ARM words or Thumb halfwords.
// Latency: flush -> mem_read next cycle, instr_valid the cycle after (zero-wait memory).
// Backpressure: instr_ready stalls delivery; fetching pauses when the buffer is full.
module cpu_prefetch_unit #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC
) (
  input  logic                 clk,
  input  logic                 rstn,
  cpu_prefetch_unit_if.master  bus
);
  import cpu_pkg::*;

  localparam int unsigned   CW   = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  pf_state_e     r_state;
  pf_state_e     w_state_nxt;
  logic [31:0]   r_fetch_addr;
  logic [31:0]   r_drop_addr;
  logic [31:0]   r_deliver_pc;
  logic          r_thumb;
  logic [31:0]   w_head;
  logic [CW-1:0] w_count;
  logic [CW:0]   w_post_count;
  logic          w_valid;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic [15:0]   w_half;

  pf_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_clear (bus.flush),
    .i_dat   (bus.mem_rdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // A flush cycle discards both returning data and the core's accept.
  assign w_valid      = (w_count != '0);
  assign w_accept     = w_valid && bus.instr_ready && !bus.flush;
  assign w_pop        = w_accept && (!r_thumb || r_deliver_pc[1]);
  assign w_push       = (r_state == S_REQ) && bus.mem_ok && !bus.flush;
  assign w_post_count = {1'b0, w_count} + {{CW{1'b0}}, w_push} - {{CW{1'b0}}, w_pop};

  // Next memory state; a flush either orphans the in-flight read or restarts fetching at once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_count < FULL) w_state_nxt = S_REQ;
      S_REQ:   if (bus.mem_ok) w_state_nxt = (w_post_count < {1'b0, FULL}) ? S_REQ : S_IDLE;
      // The buffer is necessarily empty after a drop, so request again right away.
      S_DROP:  if (bus.mem_ok) w_state_nxt = S_REQ;
      default: w_state_nxt = S_IDLE;
    endcase
    if (bus.flush) begin
      if ((r_state != S_IDLE) && !bus.mem_ok) w_state_nxt = S_DROP;
      else                                    w_state_nxt = S_REQ;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rstn) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Fetch address; the orphaned read keeps its own copy so mem_addr stays stable.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_fetch_addr <= RESET_PC;
      r_drop_addr  <= RESET_PC;
    end else begin
      if (bus.flush && (r_state == S_REQ) && !bus.mem_ok) r_drop_addr <= r_fetch_addr;
      if (bus.flush)   r_fetch_addr <= {bus.flush_pc[31:2], 2'b00};
      else if (w_push) r_fetch_addr <= r_fetch_addr + 32'd4;
    end
  end

  // Delivery address and instruction set state.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_deliver_pc <= RESET_PC;
      r_thumb      <= 1'b0;
    end else if (bus.flush) begin
      r_deliver_pc <= bus.flush_thumb ? {bus.flush_pc[31:1], 1'b0} : {bus.flush_pc[31:2], 2'b00};
      r_thumb      <= bus.flush_thumb;
    end else if (w_accept) begin
      r_deliver_pc <= r_deliver_pc + (r_thumb ? 32'd2 : 32'd4);
    end
  end

  assign w_half          = r_deliver_pc[1] ? w_head[31:16] : w_head[15:0];
  assign bus.instr_valid = w_valid;
  assign bus.instr       = !w_valid ? 32'h0 : (r_thumb ? {16'h0, w_half} : w_head);
  assign bus.instr_pc    = r_deliver_pc;
  assign bus.mem_read    = (r_state != S_IDLE);
  assign bus.mem_addr    = (r_state == S_DROP) ? r_drop_addr : r_fetch_addr;
  assign bus.mem_width   = MW_WORD;
endmodule

// File: tb/tb_cpu_prefetch_unit.sv
module tb_cpu_prefetch_unit;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] RST_PC = 32'h0800_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic clk;
  logic rstn;
  cpu_prefetch_unit_if bus();

  cpu_prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RST_PC)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   wait_min = 0;
  int   wait_max = 0;
  int   busy = 0;
  int   left = 0;
  bit   prev_hold = 0;
  logic [31:0] prev_addr = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory contents: every word holds its own address, except one marked word.
  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return (a == 32'h0800_0100) ? 32'hBBBB_AAAA : a;
  endfunction

  // Reference instruction stream seen by the core after a redirect to pc.
  task automatic load_stream(input logic [31:0] pc, input bit th);
    logic [31:0] a;
    logic [31:0] w;
    exp_t e;
    exp_q.delete();
    a = th ? {pc[31:1], 1'b0} : {pc[31:2], 2'b00};
    for (int k = 0; k < 96; k++) begin
      w     = mem_data({a[31:2], 2'b00});
      e.pc  = a;
      e.ins = !th ? w : (a[1] ? {16'h0, w[31:16]} : {16'h0, w[15:0]});
      exp_q.push_back(e);
      a = a + (th ? 32'd2 : 32'd4);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush(input logic [31:0] pc, input bit th);
    bus.flush       = 1'b1;
    bus.flush_pc    = pc;
    bus.flush_thumb = th;
    load_stream(pc, th);
    step();
    bus.flush       = 1'b0;
    bus.flush_pc    = $urandom;
    bus.flush_thumb = 1'($urandom_range(1, 0));
  endtask

  // Memory slave: random wait states per request, one-cycle mem_ok, abort when mem_read drops.
  always @(negedge clk) begin
    if (rstn && bus.mem_read) begin
      if (busy == 0) begin
        busy = 1;
        left = $urandom_range(wait_max, wait_min);
      end
      if (left == 0) begin
        bus.mem_ok    = 1'b1;
        bus.mem_rdata = mem_data(bus.mem_addr);
        busy          = 0;
      end else begin
        bus.mem_ok    = 1'b0;
        bus.mem_rdata = 32'hDEAD_BEEF;
        left--;
      end
    end else begin
      bus.mem_ok    = 1'b0;
      bus.mem_rdata = 32'hDEAD_BEEF;
      busy          = 0;
    end
  end

  // Monitor: pops the expected stream on every accepted instruction and checks bus rules.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rstn) begin
      chk("mem_width", 32'(bus.mem_width), 32'd2);
      chk("mem_addr_align", 32'(bus.mem_addr[1:0]), 32'd0);
      if (!bus.instr_valid) chk("instr_zero_when_invalid", bus.instr, 32'h0);
      if (prev_hold) begin
        chk("hold_mem_read", 32'(bus.mem_read), 32'd1);
        chk("hold_mem_addr", bus.mem_addr, prev_addr);
      end
      if (bus.instr_valid && bus.instr_ready && !bus.flush) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream_underflow: got pc %h with no expected entry", bus.instr_pc);
        end else begin
          e = exp_q.pop_front();
          chk("stream_pc", bus.instr_pc, e.pc);
          chk("stream_instr", bus.instr, e.ins);
        end
      end
    end
    prev_hold = rstn && bus.mem_read && !bus.mem_ok;
    prev_addr = bus.mem_addr;
  end

  initial begin
    int n;
    bit found;
    logic [31:0] pc;
    int len;

    rstn            = 1'b0;
    bus.instr_ready = 1'b0;
    bus.flush       = 1'b0;
    bus.flush_pc    = '0;
    bus.flush_thumb = 1'b0;
    load_stream(RST_PC, 1'b0);
    repeat (3) step();

    // Reset values.
    chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, RST_PC);
    chk("rst_mem_width", 32'(bus.mem_width), 32'd2);
    chk("rst_instr_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst_instr", bus.instr, 32'h0);
    chk("rst_instr_pc", bus.instr_pc, RST_PC);

    // First fetch and back-to-back ARM delivery with zero-wait memory.
    rstn = 1'b1;
    step();
    chk("boot_mem_read", 32'(bus.mem_read), 32'd1);
    chk("boot_mem_addr", bus.mem_addr, RST_PC);
    chk("boot_valid_c1", 32'(bus.instr_valid), 32'd0);
    bus.instr_ready = 1'b1;
    step();
    chk("boot_instr0", bus.instr, 32'h0800_0000);
    step();
    chk("boot_instr1", bus.instr, 32'h0800_0004);
    step();
    chk("boot_instr2", bus.instr, 32'h0800_0008);
    chk("boot_pc2", bus.instr_pc, 32'h0800_0008);

    // Core stall: buffer fills with exactly DEPTH reads, then one accept restarts fetch.
    bus.instr_ready = 1'b0;
    do_flush(RST_PC, 1'b0);
    n = 0;
    repeat (12) begin
      step();
      if (bus.mem_ok) n++;
    end
    chk("stall_reads", 32'(n), 32'(DEPTH));
    chk("stall_mem_read", 32'(bus.mem_read), 32'd0);
    chk("stall_valid", 32'(bus.instr_valid), 32'd1);
    chk("stall_instr", bus.instr, RST_PC);
    bus.instr_ready = 1'b1;
    step();
    bus.instr_ready = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 4 && !found; c++) begin
      step();
      if (bus.mem_read) found = 1'b1;
    end
    chk("restart_seen", 32'(found), 32'd1);
    chk("restart_addr", bus.mem_addr, 32'h0800_0010);
    repeat (4) step();

    // Thumb redirect to an odd halfword: upper half of the first word first.
    do_flush(32'h0800_0102, 1'b1);
    chk("thumb_mem_read", 32'(bus.mem_read), 32'd1);
    chk("thumb_mem_addr", bus.mem_addr, 32'h0800_0100);
    step();
    chk("thumb_valid", 32'(bus.instr_valid), 32'd1);
    chk("thumb_instr", bus.instr, 32'h0000_BBBB);
    chk("thumb_pc", bus.instr_pc, 32'h0800_0102);
    chk("thumb_next_addr", bus.mem_addr, 32'h0800_0104);
    bus.instr_ready = 1'b1;
    repeat (6) step();

    // Flush during a 3-wait-state read: address held, data dropped, then new target.
    bus.instr_ready = 1'b0;
    wait_min = 3;
    wait_max = 3;
    do_flush(32'h0800_0020, 1'b0);
    chk("drop_first_addr", bus.mem_addr, 32'h0800_0020);
    step();
    do_flush(32'h0800_0200, 1'b0);
    chk("drop_mem_read", 32'(bus.mem_read), 32'd1);
    chk("drop_addr_after_flush", bus.mem_addr, 32'h0800_0020);
    found = 1'b0;
    for (int c = 0; c < 8 && !found; c++) begin
      step();
      if (bus.mem_ok) found = 1'b1;
      else chk("drop_hold_addr", bus.mem_addr, 32'h0800_0020);
    end
    chk("drop_ok_seen", 32'(found), 32'd1);
    chk("drop_valid", 32'(bus.instr_valid), 32'd0);
    chk("drop_new_read", 32'(bus.mem_read), 32'd1);
    chk("drop_new_addr", bus.mem_addr, 32'h0800_0200);
    wait_min = 0;
    wait_max = 0;
    bus.instr_ready = 1'b1;
    repeat (10) step();

    // Flush coinciding with mem_ok: the returned word must not appear.
    chk("same_pre_read", 32'(bus.mem_read), 32'd1);
    do_flush(32'h0800_0300, 1'b1);
    chk("same_ok_at_flush", 32'(bus.mem_ok), 32'd1);
    chk("same_valid", 32'(bus.instr_valid), 32'd0);
    chk("same_addr", bus.mem_addr, 32'h0800_0300);
    repeat (8) step();

    // Reset in the middle of an outstanding read.
    wait_min = 3;
    wait_max = 3;
    do_flush(32'h0800_0400, 1'b0);
    step();
    rstn = 1'b0;
    load_stream(RST_PC, 1'b0);
    step();
    chk("rst2_mem_read", 32'(bus.mem_read), 32'd0);
    chk("rst2_mem_addr", bus.mem_addr, RST_PC);
    chk("rst2_mem_width", 32'(bus.mem_width), 32'd2);
    chk("rst2_valid", 32'(bus.instr_valid), 32'd0);
    chk("rst2_instr", bus.instr, 32'h0);
    chk("rst2_pc", bus.instr_pc, RST_PC);
    rstn = 1'b1;

    // Random traffic: random stalls, wait states and redirects, including address wrap.
    for (int s = 0; s < 60; s++) begin
      len      = $urandom_range(40, 5);
      wait_min = 0;
      wait_max = $urandom_range(3, 0);
      for (int c = 0; c < len; c++) begin
        bus.instr_ready = ($urandom_range(3, 0) != 0);
        step();
      end
      if ($urandom_range(3, 0) == 0) pc = 32'hFFFF_FFF0 + 32'($urandom_range(7, 0) * 2);
      else                           pc = 32'h0800_0000 + 32'($urandom_range(4095, 0));
      bus.instr_ready = 1'($urandom_range(1, 0));
      do_flush(pc, 1'($urandom_range(1, 0)));
    end
    bus.instr_ready = 1'b1;
    repeat (20) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
